xor_squash_pipe: RTL and testbench

//   Pipelined, parametrised XOR-squash with valid/ready handshake. Each accepted

---
 rtl/xor_squash_pipe.sv | 117 +++++++++++
 tb/tb_xor_squash_pipe.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/xor_squash_pipe.sv
// Two-stage XOR-squash with valid/ready handshake: lane-wise A^B, fold to one lane,
// XOR-accumulate per packet. Optional result parity under XOR_SQUASH_PARITY_EN.
module xor_squash_pipe #(
  parameter int unsigned TOTAL_WIDTH  = 128,
  parameter int unsigned SQUASH_WIDTH = 8,
  parameter int unsigned CNT_WIDTH    = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic                     in_last_i,
  input  logic [TOTAL_WIDTH/2-1:0] first_op_i,
  input  logic [TOTAL_WIDTH/2-1:0] second_op_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [SQUASH_WIDTH-1:0]  result_o,
  output logic [CNT_WIDTH-1:0]     beats_o
`ifdef XOR_SQUASH_PARITY_EN
  ,
  output logic                     result_par_o
`endif
);

  localparam int unsigned OpWidth  = TOTAL_WIDTH / 2;
  localparam int unsigned NumLanes = OpWidth / SQUASH_WIDTH;

  logic                    stall;
  logic                    accept;
  logic                    load;
  logic                    s1_valid_q;
  logic                    s1_last_q;
  logic [OpWidth-1:0]      s1_lanes_q;
  logic [SQUASH_WIDTH-1:0] fold;
  logic [SQUASH_WIDTH-1:0] acc_q, acc_n;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_n;
  logic [SQUASH_WIDTH-1:0] result_q;
  logic [CNT_WIDTH-1:0]    beats_q;
  logic                    out_valid_q;

  assign stall      = out_valid_q && !out_ready_i;
  assign in_ready_o = !stall;
  assign accept     = in_valid_i && !stall;

  // Stage 1: lane-wise XOR of the operands.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_lanes_q <= '0;
    end else if (!stall) begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_last_q  <= in_last_i;
        s1_lanes_q <= first_op_i ^ second_op_i;
      end
    end
  end

  always_comb begin
    fold = '0;
    for (int k = 0; k < NumLanes; k++) begin
      fold = fold ^ s1_lanes_q[k*SQUASH_WIDTH +: SQUASH_WIDTH];
    end
    acc_n = acc_q ^ fold;
    cnt_n = (cnt_q == {CNT_WIDTH{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    load  = s1_valid_q && !stall && s1_last_q;
  end

  // Stage 2: per-packet accumulation and result register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      beats_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (s1_valid_q && !stall) begin
        if (s1_last_q) begin
          result_q <= acc_n;
          beats_q  <= cnt_n;
          acc_q    <= '0;
          cnt_q    <= '0;
        end else begin
          acc_q <= acc_n;
          cnt_q <= cnt_n;
        end
      end
      // A fresh load wins over a same-cycle handshake.
      if (load) begin
        out_valid_q <= 1'b1;
      end else if (out_ready_i) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign beats_o     = beats_q;

`ifdef XOR_SQUASH_PARITY_EN
  logic par_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      par_q <= 1'b0;
    end else if (load) begin
      par_q <= ^acc_n;
    end
  end

  assign result_par_o = par_q;
`endif

endmodule

// File: tb/tb_xor_squash_pipe.sv
// Directed bench for xor_squash_pipe: reset, single/multi-beat packets, backpressure,
// mid-packet reset and beat-counter saturation.
module tb_xor_squash_pipe;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic        in_last_i;
  logic [63:0] first_op_i;
  logic [63:0] second_op_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [7:0]  result_o;
  logic [7:0]  beats_o;
`ifdef XOR_SQUASH_PARITY_EN
  logic        result_par_o;
`endif

  int checks = 0;
  int errors = 0;

  xor_squash_pipe #(
    .TOTAL_WIDTH (128),
    .SQUASH_WIDTH(8),
    .CNT_WIDTH   (8)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_last_i   (in_last_i),
    .first_op_i  (first_op_i),
    .second_op_i (second_op_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .result_o    (result_o),
    .beats_o     (beats_o)
`ifdef XOR_SQUASH_PARITY_EN
    ,
    .result_par_o(result_par_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [63:0] a, input logic [63:0] b, input logic last);
    in_valid_i  = 1'b1;
    first_op_i  = a;
    second_op_i = b;
    in_last_i   = last;
  endtask

  initial begin
    rst_i       = 1'b1;
    in_valid_i  = 1'b0;
    in_last_i   = 1'b0;
    first_op_i  = '0;
    second_op_i = '0;
    out_ready_i = 1'b1;
    step();
    step();
    chk("rst_out_valid", 64'(out_valid_o), 64'd0);
    chk("rst_result", 64'(result_o), 64'd0);
    chk("rst_beats", 64'(beats_o), 64'd0);
    chk("rst_in_ready", 64'(in_ready_o), 64'd1);
    rst_i = 1'b0;

    // 1: single beat, latency
    beat(64'h0102030405060708, 64'h0, 1'b1);
    step();
    in_valid_i = 1'b0;
    chk("t1_valid_early", 64'(out_valid_o), 64'd0);
    step();
    chk("t1_valid", 64'(out_valid_o), 64'd1);
    chk("t1_result", 64'(result_o), 64'h08);
    chk("t1_beats", 64'(beats_o), 64'd1);
    step();
    chk("t1_valid_clear", 64'(out_valid_o), 64'd0);

    // 2: A == B
    beat(64'hDEADBEEF12345678, 64'hDEADBEEF12345678, 1'b1);
    step();
    in_valid_i = 1'b0;
    step();
    chk("t2_valid", 64'(out_valid_o), 64'd1);
    chk("t2_result", 64'(result_o), 64'h00);
    chk("t2_beats", 64'(beats_o), 64'd1);

    // 3: three-beat packet, then a fresh packet from acc=0
    beat(64'hFF, 64'h0, 1'b0);
    step();
    beat(64'hFF, 64'h0, 1'b0);
    step();
    beat(64'hFF, 64'h0, 1'b1);
    step();
    in_valid_i = 1'b0;
    step();
    chk("t3_valid", 64'(out_valid_o), 64'd1);
    chk("t3_result", 64'(result_o), 64'hFF);
    chk("t3_beats", 64'(beats_o), 64'd3);
    beat(64'h11, 64'h0, 1'b1);
    step();
    in_valid_i = 1'b0;
    step();
    chk("t3_next_result", 64'(result_o), 64'h11);
    chk("t3_next_beats", 64'(beats_o), 64'd1);
    step();

    // 4: backpressure with input pending
    out_ready_i = 1'b0;
    beat(64'h21, 64'h0, 1'b1);
    step();
    beat(64'h42, 64'h0, 1'b1);
    step();
    beat(64'h84, 64'h0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_in_ready_stall", 64'(in_ready_o), 64'd0);
      chk("t4_valid_hold", 64'(out_valid_o), 64'd1);
      chk("t4_result_hold", 64'(result_o), 64'h21);
      chk("t4_beats_hold", 64'(beats_o), 64'd1);
    end
    out_ready_i = 1'b1;
    #1;
    chk("t4_in_ready_release", 64'(in_ready_o), 64'd1);
    step();
    in_valid_i = 1'b0;
    chk("t4_p2_valid", 64'(out_valid_o), 64'd1);
    chk("t4_p2_result", 64'(result_o), 64'h42);
    step();
    chk("t4_p3_valid", 64'(out_valid_o), 64'd1);
    chk("t4_p3_result", 64'(result_o), 64'h84);
    step();
    chk("t4_drained", 64'(out_valid_o), 64'd0);

    // 5: reset mid-packet discards partial accumulation
    beat(64'h33, 64'h0, 1'b0);
    step();
    beat(64'h33, 64'h0, 1'b0);
    step();
    in_valid_i = 1'b0;
    rst_i      = 1'b1;
    step();
    rst_i = 1'b0;
    chk("t5_rst_valid", 64'(out_valid_o), 64'd0);
    chk("t5_rst_result", 64'(result_o), 64'h00);
    beat(64'h5A, 64'h0, 1'b1);
    step();
    in_valid_i = 1'b0;
    step();
    chk("t5_valid", 64'(out_valid_o), 64'd1);
    chk("t5_result", 64'(result_o), 64'h5A);
    chk("t5_beats", 64'(beats_o), 64'd1);
    step();

    // 6: 300-beat packet saturates the beat counter
    for (int i = 0; i < 300; i++) begin
      beat((i == 0) ? 64'h08 : 64'h0, 64'h0, (i == 299));
      step();
    end
    in_valid_i = 1'b0;
    step();
    chk("t6_valid", 64'(out_valid_o), 64'd1);
    chk("t6_result", 64'(result_o), 64'h08);
    chk("t6_beats", 64'(beats_o), 64'hFF);
`ifdef XOR_SQUASH_PARITY_EN
    chk("t6_parity", 64'(result_par_o), 64'd1);
`endif
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
